light_phase_timer: RTL

- Upstream timing stage for the two-street traffic-light controller FSM.
- Watches the FSM's one-hot phase indicators (fsm_g, fsm_y, fsm_r) and counts how long the current phase has lasted.
- Issues single-cycle g_end / y_end / r_end pulses that tell the FSM to advance.
- Also provides a remaining-time countdown for a display, plus a phase-indicator error flag.

---
 rtl/light_phase_timer_pkg.sv | 31 +++
 rtl/light_phase_timer_if.sv | 26 ++
 rtl/light_phase_timer_tick_prescaler.sv | 33 +++
 rtl/light_phase_timer.sv | 85 ++++++++
 4 files changed

// File: rtl/light_phase_timer_pkg.sv
// Shared phase encodings, default durations and the phase-to-duration lookup.
package light_timer_pkg;

  // One-hot phase vector {fsm_g, fsm_y, fsm_r}
  localparam logic [2:0] PH_G = 3'b100;
  localparam logic [2:0] PH_Y = 3'b010;
  localparam logic [2:0] PH_R = 3'b001;

  localparam int unsigned DEF_TICK_DIV = 1;
  localparam int unsigned DEF_G_TICKS  = 30;
  localparam int unsigned DEF_Y_TICKS  = 5;
  localparam int unsigned DEF_R_TICKS  = 2;
  localparam int unsigned DEF_CNT_W    = 8;
  localparam int unsigned DEF_DIV_W    = 8;

  // Duration in ticks for a phase vector; 0 when the vector is not one-hot
  function automatic int unsigned phase_dur(input logic [2:0] ph,
                                            input int unsigned g_ticks,
                                            input int unsigned y_ticks,
                                            input int unsigned r_ticks);
    int unsigned d;
    case (ph)
      PH_G:    d = g_ticks;
      PH_Y:    d = y_ticks;
      PH_R:    d = r_ticks;
      default: d = 0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/light_phase_timer_if.sv
// Phase indicators and hold from the traffic FSM side, timing results back to it.
interface light_phase_timer_if #(
  parameter int unsigned CNT_W = 8
);
  logic             fsm_g;
  logic             fsm_y;
  logic             fsm_r;
  logic             hold;
  logic             g_end;
  logic             y_end;
  logic             r_end;
  logic [CNT_W-1:0] remain;
  logic             phase_err;

  // FSM side: drives phase indicators and hold, consumes end pulses
  modport master (
    output fsm_g, fsm_y, fsm_r, hold,
    input  g_end, y_end, r_end, remain, phase_err
  );

  // Timer side
  modport slave (
    input  fsm_g, fsm_y, fsm_r, hold,
    output g_end, y_end, r_end, remain, phase_err
  );
endinterface

// File: rtl/light_phase_timer_tick_prescaler.sv
// Divides clk into timer ticks; clr restarts the division in the same cycle.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned DIV_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  logic [DIV_W-1:0] pre;
  logic [DIV_W-1:0] eff_pre;

  // Effective prescale count and tick for this cycle
  always_comb begin
    eff_pre = clr ? '0 : pre;
    tick    = en & (eff_pre == DIV_W'(TICK_DIV - 1));
  end

  // Advance while enabled, otherwise hold the effective value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
    end else if (en) begin
      pre <= tick ? '0 : eff_pre + DIV_W'(1);
    end else begin
      pre <= eff_pre;
    end
  end

endmodule

// File: rtl/light_phase_timer.sv
// Times each traffic-light phase and pulses the matching end signal when it elapses.
module light_phase_timer
  import light_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV,
  parameter int unsigned G_TICKS  = DEF_G_TICKS,
  parameter int unsigned Y_TICKS  = DEF_Y_TICKS,
  parameter int unsigned R_TICKS  = DEF_R_TICKS,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned DIV_W    = DEF_DIV_W
) (
  input logic               clk,
  input logic               rst,
  light_phase_timer_if.slave bus
);

  logic [2:0]       ph;
  logic [2:0]       prev_ph;
  logic             valid;
  logic             chg;
  logic             tick;
  logic             last;
  logic             pre_en;
  logic             pre_clr;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] eff_cnt;
  logic [CNT_W-1:0] dur;
  logic [CNT_W-1:0] remain_c;
  logic             phase_err;

  // Phase decode, change detect and end-of-phase detection
  always_comb begin
    ph       = {bus.fsm_g, bus.fsm_y, bus.fsm_r};
    valid    = $onehot(ph);
    chg      = (ph != prev_ph);
    eff_cnt  = chg ? '0 : cnt;
    dur      = CNT_W'(phase_dur(ph, G_TICKS, Y_TICKS, R_TICKS));
    pre_en   = valid & ~bus.hold;
    pre_clr  = chg | ~valid;
    last     = tick & (eff_cnt == dur - CNT_W'(1));
    remain_c = valid ? dur - eff_cnt : '0;
  end

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .DIV_W    (DIV_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .en   (pre_en),
    .tick (tick)
  );

  // Phase history, tick count and error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_ph   <= 3'b000;
      cnt       <= '0;
      phase_err <= 1'b0;
    end else begin
      prev_ph   <= ph;
      phase_err <= ~valid;
      if (!valid) begin
        cnt <= '0;
      end else if (bus.hold) begin
        cnt <= eff_cnt;
      end else if (last) begin
        cnt <= '0;
      end else if (tick) begin
        cnt <= eff_cnt + CNT_W'(1);
      end else begin
        cnt <= eff_cnt;
      end
    end
  end

  // End pulses are suppressed while reset is asserted
  assign bus.g_end     = last & bus.fsm_g & ~rst;
  assign bus.y_end     = last & bus.fsm_y & ~rst;
  assign bus.r_end     = last & bus.fsm_r & ~rst;
  assign bus.remain    = remain_c;
  assign bus.phase_err = phase_err;

endmodule
